online_residual_select: RTL and testbench

- Sequential selection-and-residual stage of an online (MSD-first) multiplier/divider datapath.
- Sits directly downstream of the 4:2 carry-save compressor.
- Registers the compressor's redundant residual (ws/wc) each iteration and selects an output digit z in {-1,0,+1} from a short estimate of the top bits.
- Drives the updated residual 2·(v − z) back to the compressor as feedback operands, and sequences warm-up (online delay) and digit count per operation.

---
 rtl/online_residual_select.sv | 199 +++++++++++++++++++
 tb/tb_online_residual_select.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/online_residual_select.sv
// ============================================================================
// Module   : online_residual_select
// Function : Residual register, digit selection and feedback stage of an online
//            (MSD-first) datapath, fed by the 4:2 carry-save compressor.
//            Optional bound checker (err port) under ONLINE_RESIDUAL_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module online_residual_select #(
    parameter int WIDTH    = 16,
    parameter int EST_BITS = 4,
    parameter int N_DIGITS = 16,
    parameter int DELTA    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ws_in,
    input  logic [WIDTH-1:0] wc_in,
    output logic             busy,
    output logic             out_valid,
    output logic             z_pos,
    output logic             z_neg,
    output logic             done,
    output logic [WIDTH-1:0] ws_fb,
    output logic [WIDTH-1:0] wc_fb
`ifdef ONLINE_RESIDUAL_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SELECT = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(DELTA + N_DIGITS + 1);
    localparam logic [CNT_W-1:0] WARM_END = CNT_W'(DELTA);
    localparam logic [CNT_W-1:0] LAST_END = CNT_W'(DELTA + N_DIGITS);

    // Estimate LSB weighs 2^-(EST_BITS-2), so 1/2 is 1 << (EST_BITS-3).
    localparam logic signed [EST_BITS-1:0] EST_HALF_P = EST_BITS'(1) << (EST_BITS - 3);
    localparam logic signed [EST_BITS-1:0] EST_HALF_N = -EST_HALF_P;

    // Weight-1 bit of the residual, restricted to the bits that survive the shift.
    localparam logic [WIDTH-2:0] ONE_LO = (WIDTH-1)'(1) << (WIDTH - 2);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [WIDTH-1:0]      ws_q, ws_d;
    logic [WIDTH-1:0]      wc_q, wc_d;
    logic                  sel_q, sel_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;
    logic                  w_start_acc;
    logic signed [EST_BITS-1:0] w_est;
    logic                  w_z_pos;
    logic                  w_z_neg;
    logic [WIDTH-2:0]      w_ws_adj;

    function automatic logic signed [EST_BITS-1:0] est_f(
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] c
    );
        return s[WIDTH-1 -: EST_BITS] + c[WIDTH-1 -: EST_BITS];
    endfunction

    // done_q keeps busy high in the first IDLE cycle, so start is refused there too.
    assign w_start_acc = (state_q == ST_IDLE) && start && !done_q;
    assign w_cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ws_d        = ws_q;
        wc_d        = wc_q;
        sel_d       = sel_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_start_acc) begin
                    state_d = (DELTA == 0) ? ST_SELECT : ST_WARMUP;
                    cnt_d   = '0;
                    ws_d    = '0;
                    wc_d    = '0;
                    sel_d   = 1'b0;
                end
            end
            ST_WARMUP: begin
                if (in_valid) begin
                    ws_d  = ws_in;
                    wc_d  = wc_in;
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == WARM_END) begin
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_SELECT: begin
                if (in_valid) begin
                    ws_d        = ws_in;
                    wc_d        = wc_in;
                    cnt_d       = w_cnt_inc;
                    sel_d       = 1'b1;
                    out_valid_d = 1'b1;
                    if (w_cnt_inc == LAST_END) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ws_q        <= '0;
            wc_q        <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ws_q        <= ws_d;
            wc_q        <= wc_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Digit selection; warm-up values always give z = 0.
    assign w_est   = est_f(ws_q, wc_q);
    assign w_z_pos = sel_q && (w_est >= EST_HALF_P);
    assign w_z_neg = sel_q && (w_est <  EST_HALF_N);

    always_comb begin
        w_ws_adj = ws_q[WIDTH-2:0];
        if (w_z_pos) begin
            w_ws_adj = ws_q[WIDTH-2:0] - ONE_LO;
        end else if (w_z_neg) begin
            w_ws_adj = ws_q[WIDTH-2:0] + ONE_LO;
        end
    end

    assign ws_fb     = {w_ws_adj, 1'b0};
    assign wc_fb     = {wc_q[WIDTH-2:0], 1'b0};
    assign z_pos     = w_z_pos;
    assign z_neg     = w_z_neg;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE) || done_q;

`ifdef ONLINE_RESIDUAL_CHECK_EN
    localparam logic signed [EST_BITS-1:0] EST_3HALF_P = EST_BITS'(3) << (EST_BITS - 3);
    localparam logic signed [EST_BITS-1:0] EST_3HALF_N = -EST_3HALF_P;

    logic                       err_q, err_d;
    logic                       w_capture;
    logic signed [EST_BITS-1:0] w_est_in;

    assign w_capture = in_valid && ((state_q == ST_WARMUP) || (state_q == ST_SELECT));
    assign w_est_in  = est_f(ws_in, wc_in);

    always_comb begin
        err_d = err_q;
        if (w_start_acc) begin
            err_d = 1'b0;
        end else if (w_capture && ((w_est_in >= EST_3HALF_P) || (w_est_in < EST_3HALF_N))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_online_residual_select.sv
// Testbench for online_residual_select: directed vector table plus randomized
// operations compared against an arithmetic model of the selection rules.
`default_nettype none

module tb_online_residual_select;

    localparam int WIDTH    = 16;
    localparam int EST_BITS = 4;
    localparam int N_DIGITS = 16;
    localparam int DELTA    = 3;
    localparam int N_VEC    = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] ws_in;
    logic [15:0] wc_in;
    logic        busy;
    logic        out_valid;
    logic        z_pos;
    logic        z_neg;
    logic        done;
    logic [15:0] ws_fb;
    logic [15:0] wc_fb;
`ifdef ONLINE_RESIDUAL_CHECK_EN
    logic        err;
`endif

    online_residual_select #(
        .WIDTH   (WIDTH),
        .EST_BITS(EST_BITS),
        .N_DIGITS(N_DIGITS),
        .DELTA   (DELTA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .ws_in    (ws_in),
        .wc_in    (wc_in),
        .busy     (busy),
        .out_valid(out_valid),
        .z_pos    (z_pos),
        .z_neg    (z_neg),
        .done     (done),
        .ws_fb    (ws_fb),
        .wc_fb    (wc_fb)
`ifdef ONLINE_RESIDUAL_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ws;
        logic [15:0] wc;
        logic        zp;
        logic        zn;
        logic [15:0] wsfb;
        logic [15:0] wcfb;
    } vec_t;

    vec_t        vt [N_VEC];
    int          checks   = 0;
    int          failures = 0;
    int          npulse;
    logic        e_zp;
    logic        e_zn;
    logic [15:0] e_wsfb;
    logic [15:0] e_wcfb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Residual value rules: estimate in quarter units from the top nibbles,
    // z from the +-1/2 thresholds, feedback = 2*(v - z) as plain integers.
    function automatic void model(input logic [15:0] ws, input logic [15:0] wc,
                                  output logic zp, output logic zn,
                                  output logic [15:0] fs, output logic [15:0] fc);
        int e;
        int z;
        int t;
        e = (int'(ws >> 12) + int'(wc >> 12)) % 16;
        if (e >= 8) e = e - 16;
        z  = (e >= 2) ? 1 : ((e < -2) ? -1 : 0);
        t  = (int'(ws) - z * 16384) * 2;
        fs = 16'(t);
        fc = 16'(int'(wc) * 2);
        zp = (z == 1);
        zn = (z == -1);
    endfunction

    task automatic beat(input logic [15:0] ws, input logic [15:0] wc, input bit warm, input bit last);
        ws_in    = ws;
        wc_in    = wc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model(ws, wc, e_zp, e_zn, e_wsfb, e_wcfb);
        if (warm) begin
            e_zp   = 1'b0;
            e_zn   = 1'b0;
            e_wsfb = 16'(int'(ws) * 2);
        end
        if (out_valid) npulse++;
        chk("out_valid", 32'(out_valid), 32'(!warm));
        chk("digit",     32'({z_pos, z_neg}), 32'({e_zp, e_zn}));
        chk("ws_fb",     32'(ws_fb), 32'(e_wsfb));
        chk("wc_fb",     32'(wc_fb), 32'(e_wcfb));
        chk("done",      32'(done), 32'(last));
        chk("busy",      32'(busy), 32'd1);
    endtask

    task automatic gap_cycle(input bit poke_start);
        start = poke_start;
        ws_in = 16'($urandom);
        wc_in = 16'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("gap_out_valid", 32'(out_valid), 32'd0);
        chk("gap_done",      32'(done), 32'd0);
        chk("gap_busy",      32'(busy), 32'd1);
        chk("gap_hold",      {z_pos, z_neg, ws_fb, wc_fb[13:0]},
                             {e_zp, e_zn, e_wsfb, e_wcfb[13:0]});
    endtask

    // abort_at: beat index after which rst is pulsed (-1 = run to completion).
    task automatic run_op(input int gap, input bit start_beat, input bit use_vec,
                          input int abort_at, input bit poke_start);
        logic [15:0] ws;
        logic [15:0] wc;
        int          vi;
        npulse   = 0;
        e_zp     = 1'b0;
        e_zn     = 1'b0;
        e_wsfb   = 16'h0;
        e_wcfb   = 16'h0;
        start    = 1'b1;
        in_valid = start_beat;
        ws_in    = 16'h6000;
        wc_in    = 16'($urandom);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_busy",   32'(busy), 32'd1);
        chk("start_ovalid", 32'(out_valid), 32'd0);
        chk("start_clear",  {ws_fb, wc_fb}, 32'h0);
        for (int k = 0; k < DELTA + N_DIGITS; k++) begin
            for (int j = 0; j < gap; j++) gap_cycle(poke_start && (j == 0));
            ws = 16'($urandom);
            wc = 16'($urandom);
            vi = k - DELTA;
            if (use_vec && k == 0) begin
                ws = 16'h2000;
                wc = 16'h0000;
            end
            if (use_vec && vi >= 0 && vi < N_VEC) begin
                beat(vt[vi].ws, vt[vi].wc, 1'b0, k == DELTA + N_DIGITS - 1);
                chk("vec_digit", 32'({z_pos, z_neg}), 32'({vt[vi].zp, vt[vi].zn}));
                chk("vec_fb",    {ws_fb, wc_fb}, {vt[vi].wsfb, vt[vi].wcfb});
            end else begin
                beat(ws, wc, k < DELTA, k == DELTA + N_DIGITS - 1);
            end
            if (k == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("abort_outputs", {busy, out_valid, done, z_pos, z_neg, ws_fb, wc_fb[10:0]}, 32'h0);
                chk("abort_wc_fb", 32'(wc_fb), 32'h0);
                return;
            end
        end
        @(posedge clk);
        #1;
        chk("end_busy",    32'(busy), 32'd0);
        chk("end_flags",   32'({out_valid, done}), 32'd0);
        chk("digit_count", 32'(npulse), 32'(N_DIGITS));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{16'h2000, 16'h0000, 1'b1, 1'b0, 16'hC000, 16'h0000};
        vt[1] = '{16'hE000, 16'h0000, 1'b0, 1'b0, 16'hC000, 16'h0000};
        vt[2] = '{16'hD000, 16'h0000, 1'b0, 1'b1, 16'h2000, 16'h0000};
        vt[3] = '{16'h1000, 16'h1000, 1'b1, 1'b0, 16'hA000, 16'h2000};
        vt[4] = '{16'h1FFF, 16'h0000, 1'b0, 1'b0, 16'h3FFE, 16'h0000};
        vt[5] = '{16'hDFFF, 16'h0000, 1'b0, 1'b1, 16'h3FFE, 16'h0000};
        vt[6] = '{16'h7000, 16'h7000, 1'b0, 1'b0, 16'hE000, 16'hE000};
        vt[7] = '{16'h6000, 16'h0000, 1'b1, 1'b0, 16'h4000, 16'h0000};
        vt[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h0000};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        ws_in    = 16'h0;
        wc_in    = 16'h0;
        for (int i = 0; i < 4; i++) begin
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            ws_in    = 16'($urandom);
            wc_in    = 16'($urandom);
            @(posedge clk);
            #1;
            chk("reset_state", {busy, out_valid, done, z_pos, z_neg, ws_fb, wc_fb[10:0]}, 32'h0);
        end
        chk("reset_wc_fb", 32'(wc_fb), 32'h0);
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        run_op(0, 1'b0, 1'b1, -1, 1'b0);
        run_op(2, 1'b0, 1'b0, -1, 1'b1);
        run_op(0, 1'b1, 1'b0, -1, 1'b0);
        run_op(1, 1'b0, 1'b0, DELTA + 4, 1'b0);
        run_op(0, 1'b0, 1'b0, -1, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_op(int'($urandom_range(2, 0)), 1'($urandom), 1'b0, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
